// File: rtl/acs_unit.sv
// ----------------------------------------------------------------------------
// acs_unit
//
// Add-compare-select unit for a rate-1/2, K=3, (7,5) octal Viterbi trellis.
// Each accepted step adds the branch metrics to the four registered path
// metrics, keeps the smaller candidate per next state, and records one
// survivor bit per state. The stored metrics are normalized and saturated.
//
// Optional feature: define ACS_BEST_EN to build the best-state comparator.
// Without it, o_best_state is tied to 0.
//
// Parameters
//   PM_W     path-metric width in bits (5..12)
//   PM_INIT  reset/flush metric for states 1..3
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_flush        synchronous trellis restart; overrides i_in_valid
//   i_in_valid     branch metrics are valid this cycle
//   i_bm_00..11    Hamming distance to codeword 00/01/10/11 (0..2)
//   o_dec_valid    decisions / metrics updated by the previous accepted step
//   o_decisions    survivor bit per next state (1 = predecessor p1)
//   o_pm_0..3      registered path metrics
//   o_best_state   index of the smallest registered metric (lowest on ties)
// ----------------------------------------------------------------------------
module acs_unit #(
    parameter int unsigned PM_W    = 6,
    parameter int unsigned PM_INIT = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_in_valid,
    input  logic [1:0]      i_bm_00,
    input  logic [1:0]      i_bm_01,
    input  logic [1:0]      i_bm_10,
    input  logic [1:0]      i_bm_11,
    output logic            o_dec_valid,
    output logic [3:0]      o_decisions,
    output logic [PM_W-1:0] o_pm_0,
    output logic [PM_W-1:0] o_pm_1,
    output logic [PM_W-1:0] o_pm_2,
    output logic [PM_W-1:0] o_pm_3,
    output logic [1:0]      o_best_state
);

    // Candidates carry one extra bit so pm + bm never wraps.
    localparam int unsigned   CW        = PM_W + 1;
    localparam logic [CW-1:0] HALF      = CW'(1) << (PM_W - 1);
    localparam logic [CW-1:0] PM_MAX    = CW'((1 << PM_W) - 1);
    localparam logic [PM_W-1:0] PM_INIT_V = PM_W'(PM_INIT);

    logic [PM_W-1:0] r_pm [4];
    logic [3:0]      r_dec;
    logic            r_dec_valid;

    logic [1:0]      w_bm [4];
    logic [CW-1:0]   w_win [4];
    logic [3:0]      w_sel;
    logic            w_all_hi;
    logic [PM_W-1:0] w_pm_next [4];

    // Branch metrics indexed by codeword value.
    assign w_bm[0] = i_bm_00;
    assign w_bm[1] = i_bm_01;
    assign w_bm[2] = i_bm_10;
    assign w_bm[3] = i_bm_11;

    // Per next state n: p0 = {n[0],0}, p1 = {n[0],1}. The p1 branch always
    // carries the complement of the p0 codeword.
    for (genvar g = 0; g < 4; g++) begin : g_acs
        localparam int P0 = (g % 2) * 2;
        localparam int P1 = P0 + 1;
        localparam int C0 = (g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 3 : 1;
        localparam int C1 = 3 - C0;

        logic [CW-1:0] w_cand0;
        logic [CW-1:0] w_cand1;

        assign w_cand0  = CW'(r_pm[P0]) + CW'(w_bm[C0]);
        assign w_cand1  = CW'(r_pm[P1]) + CW'(w_bm[C1]);
        // Strict compare: ties keep p0.
        assign w_sel[g] = (w_cand1 < w_cand0);
        assign w_win[g] = w_sel[g] ? w_cand1 : w_cand0;
    end

    // Normalize only when every survivor is in the upper half, so relative
    // distances between the four metrics are preserved.
    assign w_all_hi = (w_win[0] >= HALF) && (w_win[1] >= HALF) &&
                      (w_win[2] >= HALF) && (w_win[3] >= HALF);

    for (genvar g = 0; g < 4; g++) begin : g_norm
        logic [CW-1:0] w_norm;

        assign w_norm       = w_all_hi ? (w_win[g] - HALF) : w_win[g];
        assign w_pm_next[g] = (w_norm > PM_MAX) ? PM_MAX[PM_W-1:0] : w_norm[PM_W-1:0];
    end

    // rst > flush > in_valid. An idle cycle holds metrics and decisions.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_pm[0]     <= '0;
            r_pm[1]     <= PM_INIT_V;
            r_pm[2]     <= PM_INIT_V;
            r_pm[3]     <= PM_INIT_V;
            r_dec       <= 4'b0000;
            r_dec_valid <= 1'b0;
        end else if (i_in_valid) begin
            for (int i = 0; i < 4; i++) begin
                r_pm[i] <= w_pm_next[i];
            end
            r_dec       <= w_sel;
            r_dec_valid <= 1'b1;
        end else begin
            r_dec_valid <= 1'b0;
        end
    end

    assign o_dec_valid = r_dec_valid;
    assign o_decisions = r_dec;
    assign o_pm_0      = r_pm[0];
    assign o_pm_1      = r_pm[1];
    assign o_pm_2      = r_pm[2];
    assign o_pm_3      = r_pm[3];

`ifdef ACS_BEST_EN
    logic [1:0]      w_best;
    logic [PM_W-1:0] w_best_pm;

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        w_best    = 2'd0;
        w_best_pm = r_pm[0];
        if (r_pm[1] < w_best_pm) begin
            w_best    = 2'd1;
            w_best_pm = r_pm[1];
        end
        if (r_pm[2] < w_best_pm) begin
            w_best    = 2'd2;
            w_best_pm = r_pm[2];
        end
        if (r_pm[3] < w_best_pm) begin
            w_best    = 2'd3;
            w_best_pm = r_pm[3];
        end
    end

    assign o_best_state = w_best;
`else
    assign o_best_state = 2'b00;
`endif

endmodule

// File: doc/acs_unit.md
ACS_UNIT -- requirements
Module: acs_unit

Interface
REQ-001 Parameter PM_W, default 6: path-metric width in bits, legal range 5..12.
REQ-002 Parameter PM_INIT, default 16: reset/flush metric for states 1..3, legal range 0..2^(PM_W-1)-1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  synchronous restart of the trellis to initial metrics.
REQ-006 in_valid  input  1  the four branch metrics below are valid this cycle.
REQ-007 bm_00, bm_01, bm_10, bm_11  input  2 each  Hamming distance of the received pair to codeword 00/01/10/11 (range 0..2).
REQ-008 dec_valid  output  1  decisions and pm_* updated by the previous accepted step.
REQ-009 decisions  output  4  survivor bit per next-state; bit n=1 selects predecessor p1 of state n.
REQ-010 pm_0, pm_1, pm_2, pm_3  output  PM_W each  registered path metrics.
REQ-011 best_state  output  2  index of the minimum registered path metric.

Function
REQ-012 Trellis is rate-1/2, K=3, generators (7,5) octal; next state n has predecessors p0={n[0],0} and p1={n[0],1}.
REQ-013 Branch codewords (p0,p1) by next state: n0 (00,11), n1 (10,01), n2 (11,00), n3 (01,10).
REQ-014 On a cycle with in_valid=1 and flush=0 and rst=0, each candidate = pm[p] + bm[codeword], computed at PM_W+1 bits.
REQ-015 Select: the smaller candidate wins; on a tie p0 wins (decision bit 0).
REQ-016 Normalization: if all four winning metrics are >= 2^(PM_W-1), subtract 2^(PM_W-1) from all four before storing.
REQ-017 Saturation: any stored metric still > 2^PM_W-1 after normalization is clamped to 2^PM_W-1.
REQ-018 Latency: one cycle; pm_*, decisions and dec_valid update on the edge that samples in_valid=1.
REQ-019 dec_valid is 1 for exactly one cycle per accepted step; in_valid=0 clears dec_valid and holds pm_* and decisions.
REQ-020 flush=1: pm_0=0, pm_1..pm_3=PM_INIT, decisions=0, dec_valid=0 next cycle; flush overrides a simultaneous in_valid.
REQ-021 Back-to-back in_valid every cycle is supported with no bubbles.
REQ-022 best_state: lowest index wins ties; computed from the registered metrics, valid in the same cycle as pm_*.

Reset
REQ-023 rst=1 forces pm_0=0, pm_1..pm_3=PM_INIT, decisions=0, dec_valid=0, best_state=0 on the next edge.
REQ-024 rst has priority over flush and in_valid; a step in flight when rst is asserted is discarded.

Configuration
REQ-025 Macro ACS_BEST_EN defined: best_state implemented per REQ-022.
REQ-026 Macro ACS_BEST_EN undefined: no comparator logic instantiated; best_state is constant 0; all other behaviour unchanged.

Verification
REQ-027 Reset: assert rst 2 cycles -> pm={0,16,16,16}, decisions=0000, dec_valid=0, best_state=0.
REQ-028 One step, bm_00=0 bm_01=1 bm_10=1 bm_11=2 -> next cycle pm={0,17,2,17}, decisions=0000 (n1, n3 ties take p0), dec_valid=1, best_state=0.
REQ-029 in_valid low for 3 cycles after REQ-028 -> pm holds {0,17,2,17}, dec_valid=0 all three cycles.
REQ-030 From reset, 16 consecutive steps with all bm=2 -> after step 16 pm={0,0,0,0} (normalized from 32), no metric ever exceeds 63.
REQ-031 flush and in_valid asserted together mid-stream -> next cycle pm={0,16,16,16}, dec_valid=0.
REQ-032 rst asserted on the same cycle as in_valid=1 -> next cycle reset values of REQ-027, dec_valid=0.
